// File: rtl/system_bus_pkg.sv
// -----------------------------------------------------------------------------
// system_bus_pkg
// Shared types and helpers for the system bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANTED, TURNAROUND)
//   pick_t      : result of a round-robin search (valid flag + winning index)
//   rr_pick()   : round-robin search of a request vector starting at ptr
// -----------------------------------------------------------------------------
package system_bus_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANTED    = 2'd1,
      TURNAROUND = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_MASTERS = 3;
   localparam int DEF_TIMEOUT     = 64;

   // Indices are carried at the widest supported master count so the helper
   // can be shared by every NUM_MASTERS setting.
   localparam int MAX_MASTERS = 8;
   localparam int PTR_W       = 3;

   typedef struct packed {
      logic             vld;
      logic [PTR_W-1:0] idx;
   } pick_t;

   // Returns the first set bit of req[n-1:0] searching ptr, ptr+1, ... mod n.
   // The loop runs from the farthest offset down so the nearest hit is the
   // one left standing.
   function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                     input logic [PTR_W-1:0]       ptr,
                                     input int                     n);
      pick_t r;
      int    j;
      r = '0;
      for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= n) j = j - n;
         if ((i < n) && req[j[PTR_W-1:0]]) begin
            r.vld = 1'b1;
            r.idx = j[PTR_W-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/system_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// system_bus_arbiter_if
// Request/grant bundle between the bus masters and the arbiter.
//   mreq        : per-master level request
//   bus_done    : one-cycle completion pulse from the addressed slave
//   mgrant      : one-hot registered grant
//   grant_id    : binary index of the owner (0 when idle)
//   bus_busy    : |mgrant, registered
//   timeout_err : one-cycle pulse on forced revocation
// modport master : requester side; modport slave : arbiter side.
// -----------------------------------------------------------------------------
interface system_bus_arbiter_if #(
   parameter int NUM_MASTERS = 3,
   parameter int ID_W        = 2
);
   logic [NUM_MASTERS-1:0] mreq;
   logic                   bus_done;
   logic [NUM_MASTERS-1:0] mgrant;
   logic [ID_W-1:0]        grant_id;
   logic                   bus_busy;
   logic                   timeout_err;

   modport master (
      output mreq, bus_done,
      input  mgrant, grant_id, bus_busy, timeout_err
   );

   modport slave (
      input  mreq, bus_done,
      output mgrant, grant_id, bus_busy, timeout_err
   );
endinterface

// File: rtl/system_bus_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: finds the first requester at or after
// ptr_i (wrapping at NUM_MASTERS).
//   req_i : request vector
//   ptr_i : search start index
//   vld_o : at least one requester present
//   idx_o : winning master index
// -----------------------------------------------------------------------------
module rr_priority_picker
   import system_bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [PTR_W-1:0]       ptr_i,
   output logic                   vld_o,
   output logic [PTR_W-1:0]       idx_o
);
   logic [MAX_MASTERS-1:0] req_ext;
   pick_t                  pick;

   always_comb begin
      req_ext                    = '0;
      req_ext[NUM_MASTERS-1:0]   = req_i;
      pick                       = rr_pick(req_ext, ptr_i, NUM_MASTERS);
   end

   assign vld_o = pick.vld;
   assign idx_o = pick.idx;
endmodule

// File: rtl/system_bus_arbiter.sv
// -----------------------------------------------------------------------------
// system_bus_arbiter
// Round-robin owner selection for the shared system bus. A registered one-hot
// grant is held until bus_done, until the owner drops its request, or until
// TIMEOUT granted cycles elapse (timeout_err pulse). One idle turnaround cycle
// separates consecutive owners.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : request/grant bundle (slave modport)
// -----------------------------------------------------------------------------
module system_bus_arbiter
   import system_bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int ID_W        = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   system_bus_arbiter_if.slave  bus
);
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t             state_q, state_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       hold_q, hold_d;
   logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
   logic [ID_W-1:0]        grant_id_q, grant_id_d;
   logic                   busy_q, busy_d;
   logic                   terr_q, terr_d;

   logic                   pick_vld;
   logic [PTR_W-1:0]       pick_idx;
   logic [PTR_W-1:0]       owner_idx;
   logic                   owner_req;
   logic                   hold_last;
   logic                   release_w;
   logic                   timeout_w;

   rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req_i (bus.mreq),
      .ptr_i (rr_ptr_q),
      .vld_o (pick_vld),
      .idx_o (pick_idx)
   );

   // The owner's request is read through the grant mask, which avoids an
   // index that may be wider than the request vector.
   assign owner_idx = PTR_W'(grant_id_q);
   assign owner_req = |(mgrant_q & bus.mreq);
   assign hold_last = (hold_q == CNT_LAST);

   // Release priority: done, then abandon, then timeout. The error pulse only
   // fires when neither of the earlier causes applies.
   assign release_w = (state_q == GRANTED) && (bus.bus_done || !owner_req || hold_last);
   assign timeout_w = (state_q == GRANTED) && !bus.bus_done && owner_req && hold_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         hold_q     <= '0;
         mgrant_q   <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_q     <= hold_d;
         mgrant_q   <= mgrant_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         terr_q     <= terr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE, TURNAROUND: begin
            hold_d  = '0;
            state_d = pick_vld ? GRANTED : IDLE;
         end
         GRANTED: begin
            if (release_w) begin
               state_d  = TURNAROUND;
               hold_d   = '0;
               rr_ptr_d = (owner_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_idx + 1'b1;
            end else if (!hold_last) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   always_comb begin
      mgrant_d   = mgrant_q;
      grant_id_d = grant_id_q;
      terr_d     = 1'b0;
      case (state_q)
         IDLE, TURNAROUND: begin
            if (pick_vld) begin
               mgrant_d   = NUM_MASTERS'(1) << pick_idx;
               grant_id_d = ID_W'(pick_idx);
            end else begin
               mgrant_d   = '0;
               grant_id_d = '0;
            end
         end
         GRANTED: begin
            if (release_w) begin
               mgrant_d   = '0;
               grant_id_d = '0;
               terr_d     = timeout_w;
            end
         end
         default: begin
            mgrant_d   = '0;
            grant_id_d = '0;
         end
      endcase
      busy_d = |mgrant_d;
   end

   assign bus.mgrant      = mgrant_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.bus_busy    = busy_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_system_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_system_bus_arbiter
// Scoreboard bench: a reference model pushes the expected outputs after every
// clock edge or reset assertion; a monitor pops and compares 1 time unit later.
// -----------------------------------------------------------------------------
module tb_system_bus_arbiter;
   localparam int N  = 3;
   localparam int TO = 16;
   localparam int IW = 2;

   typedef struct {
      logic [N-1:0]  g;
      logic [IW-1:0] id;
      logic          busy;
      logic          err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   system_bus_arbiter_if #(.NUM_MASTERS(N), .ID_W(IW)) bus_if ();

   system_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO), .ID_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: current owner (-1 = nobody), search start, granted cycles.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_held  = 0;
   logic m_err   = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   task automatic m_release();
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_held  = 0;
   endtask

   // Reference model
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_err   = 1'b0;
         end else begin
            m_err = 1'b0;
            if (m_owner < 0) begin
               for (int k = 0; k < N; k++) begin
                  int c;
                  c = (m_ptr + k) % N;
                  if (m_owner < 0 && bus_if.mreq[c]) begin
                     m_owner = c;
                     m_held  = 1;
                  end
               end
            end else if (bus_if.bus_done || !bus_if.mreq[m_owner]) begin
               m_release();
            end else if (m_held == TO) begin
               m_release();
               m_err = 1'b1;
            end else begin
               m_held++;
            end
         end
         e.g    = (m_owner >= 0) ? N'(1 << m_owner) : '0;
         e.id   = (m_owner >= 0) ? IW'(m_owner) : '0;
         e.busy = (m_owner >= 0);
         e.err  = m_err;
         exp_q.push_back(e);
      end
   end

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         #1;
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk("mgrant",      int'(bus_if.mgrant),      int'(e.g));
            chk("grant_id",    int'(bus_if.grant_id),    int'(e.id));
            chk("bus_busy",    int'(bus_if.bus_busy),    int'(e.busy));
            chk("timeout_err", int'(bus_if.timeout_err), int'(e.err));
            chk("onehot",      int'($onehot0(bus_if.mgrant)), 1);
         end
      end
   end

   task automatic cyc(input logic [N-1:0] req, input logic done);
      @(negedge clk);
      bus_if.mreq     = req;
      bus_if.bus_done = done;
   endtask

   // Async reset pulse asserted between edges, released on the next negedge.
   task automatic mid_reset(input logic [N-1:0] req_after);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset           = 1'b0;
      bus_if.mreq     = req_after;
      bus_if.bus_done = 1'b0;
   endtask

   initial begin
      bus_if.mreq     = '0;
      bus_if.bus_done = 1'b0;
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single requester, done after a few granted cycles
      repeat (3) cyc(3'b000, 1'b0);
      repeat (4) cyc(3'b010, 1'b0);
      cyc(3'b010, 1'b1);
      repeat (3) cyc(3'b000, 1'b0);

      // All requesting, done on the 4th granted cycle of each owner
      for (int i = 0; i < 40; i++) cyc(3'b111, m_held == 4);
      repeat (2) cyc(3'b000, 1'b0);

      // Timeouts: master 0 alone, then master 1 joins
      for (int i = 0; i < 20; i++) cyc(3'b001, 1'b0);
      for (int i = 0; i < 40; i++) cyc(3'b011, 1'b0);
      repeat (2) cyc(3'b000, 1'b0);

      // bus_done coinciding with the timeout condition
      for (int i = 0; i < 40; i++) cyc(3'b001, m_held == TO);
      repeat (2) cyc(3'b000, 1'b0);

      // Owner abandons mid-grant
      repeat (5) cyc(3'b100, 1'b0);
      repeat (3) cyc(3'b110, 1'b0);
      repeat (3) cyc(3'b000, 1'b0);

      // Reset mid-grant, then a lone request from master 2
      repeat (4) cyc(3'b010, 1'b0);
      mid_reset(3'b100);
      repeat (6) cyc(3'b100, 1'b0);
      repeat (2) cyc(3'b110, 1'b0);
      mid_reset(3'b110);
      repeat (4) cyc(3'b110, 1'b0);

      // Random traffic with occasional async resets
      begin
         logic [N-1:0] r;
         r = '0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) mid_reset(r);
            else cyc(r, $urandom_range(0, 9) == 0);
         end
      end

      repeat (3) cyc(3'b000, 1'b0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/system_bus_arbiter.md
Name: system_bus_arbiter

Overview:
- Round-robin arbiter that shares the single system bus between NUM_MASTERS bus masters.
- Sits inside system_bus between the master request lines and the address/data mux select.
- Issues a registered one-hot grant and holds it until the owning transaction ends, the owner abandons it, or a watchdog timeout fires.
- Inserts exactly one idle turnaround cycle between consecutive owners.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT, 64, maximum cycles a grant may be held without bus_done (1..1023).
- ID_W, 2, width of grant_id; must be >= clog2(NUM_MASTERS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mreq  input  NUM_MASTERS  per-master bus request, level-sensitive.
- bus_done  input  1  one-cycle pulse from the addressed slave marking transaction completion.
- mgrant  output  NUM_MASTERS  one-hot grant, registered.
- grant_id  output  ID_W  binary index of the current owner; 0 when no grant.
- bus_busy  output  1  equals |mgrant, registered.
- timeout_err  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset values: mgrant=0, grant_id=0, bus_busy=0, timeout_err=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- Reset mid-transaction drops all outputs immediately, without waiting for an edge.

- States: IDLE, GRANTED, TURNAROUND.
- IDLE:
  - If mreq != 0 at edge k, grant the first requester found searching rr_ptr, rr_ptr+1, ... (mod NUM_MASTERS).
  - mgrant, grant_id and bus_busy are valid after edge k (one-cycle latency). Go to GRANTED with hold_cnt=0.
  - If mreq == 0, stay in IDLE.
- GRANTED, evaluated each edge in priority order:
  - (a) bus_done=1: release.
  - (b) mreq[owner]=0: release (abandon); no error.
  - (c) hold_cnt == TIMEOUT-1: release and pulse timeout_err for exactly one cycle.
  - (d) otherwise: hold_cnt+1 and keep the grant.
  - "Release" means: mgrant=0 and bus_busy=0 after that edge, rr_ptr = owner+1 (wrap to 0 at NUM_MASTERS), go to TURNAROUND.
- Simultaneous events in GRANTED:
  - bus_done together with the timeout condition: done wins, no timeout_err.
  - bus_done together with a dropped mreq: treated as a done release (behaviour is identical).
- TURNAROUND: exactly one cycle with mgrant=0. Arbitration during this cycle uses the same rule as IDLE, so the next owner's grant appears after the TURNAROUND edge. This gives a gap of exactly one idle cycle between owners.
- Requests from non-owners never preempt the current owner.
- bus_done seen in IDLE or TURNAROUND is ignored.
- A master that raises mreq while it is already the owner sees no effect.
- rr_ptr only advances on release, never on a grant.
- A sole continuous requester is re-granted after every turnaround.
- hold_cnt width: clog2(TIMEOUT+1). It saturates; it never wraps.
- Invariant: mgrant is always one-hot or zero.

Decomposition:
- Package system_bus_pkg:
  - arb_state_t enum {IDLE, GRANTED, TURNAROUND}.
  - Default NUM_MASTERS and TIMEOUT constants.
  - Function rr_pick(req, ptr) returning the winning index and a valid flag.
- One natural sub-module: rr_priority_picker, a combinational rotate/priority-encode/rotate-back block used by both IDLE and TURNAROUND.
- The FSM, counter and output registers stay in system_bus_arbiter.

Test Plan (NUM_MASTERS=3, TIMEOUT=16):
- Reset then mreq=3'b010 at edge 5 -> mgrant=3'b010 and grant_id=1 after edge 5. bus_done at edge 9 -> mgrant=0 after edge 9. rr_ptr=2.
- mreq=3'b111 held, bus_done every 4th granted cycle -> grant sequence 001,(gap),010,(gap),100,(gap),001 with exactly one zero cycle between owners.
- Master 0 granted, no bus_done, mreq held -> after 16 granted cycles mgrant=0 and timeout_err=1 for exactly one cycle. Next grant goes to master 1 if it is requesting.
- bus_done and the timeout condition in the same cycle (hold_cnt=15) -> release with timeout_err staying 0.
- Owner drops mreq mid-grant with no bus_done -> mgrant=0 after that edge, no timeout_err, rr_ptr advances.
- reset asserted mid-grant between clock edges -> mgrant, bus_busy and grant_id go to 0 immediately. After release with mreq=3'b100, the grant goes to master 2 (rr_ptr was reset to 0, search 0->1->2).
